// File: rtl/seq_detector_param_if.sv
// rtl/seq_detector_param_if.sv - stream, configuration and status bundle for seq_detector_param
// Purpose: groups the serial input, runtime configuration and match status of
//   the pattern detector so a driver and the detector share one port.
// Signals:
//   in_valid, in                       serial bit and its qualifier
//   cfg_we, cfg_pattern, cfg_len,
//   cfg_overlap                        configuration load strobe and values
//   cnt_clr                            match counter clear
//   out, match_cnt, cnt_sat            match pulse, saturating count, saturation flag
// Modports: master drives stimulus/config, slave is the detector.
interface seq_detector_param_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic               in_valid;
  logic               in;
  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               cnt_clr;
  logic               out;
  logic [CNT_W-1:0]   match_cnt;
  logic               cnt_sat;

  modport master (
    output in_valid, in, cfg_we, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
    input  out, match_cnt, cnt_sat
  );

  modport slave (
    input  in_valid, in, cfg_we, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
    output out, match_cnt, cnt_sat
  );
endinterface

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - runtime-programmable serial pattern detector with saturating match count
// Purpose: shifts in one serial bit per qualified clock and compares the most
//   recent len bits with a programmable pattern (oldest bit against pat[len-1]).
//   Produces a registered one-cycle match pulse and a saturating match counter,
//   in overlapping or non-overlapping mode.
// Ports:
//   clk  clock, all state on posedge
//   rst  synchronous active-low reset
//   bus  seq_detector_param_if.slave (stream, configuration, status)
module seq_detector_param #(
  parameter int                 MAX_LEN     = 8,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = 8'b0000_0101,
  parameter int                 RST_LEN     = 3,
  parameter logic               RST_OVERLAP = 1'b1,
  parameter int                 CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_detector_param_if.slave  bus
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [MAX_LEN-1:0] hist;
  logic [LEN_W-1:0]   fill;
  logic [MAX_LEN-1:0] pat;
  logic [LEN_W-1:0]   len;
  logic               ovl;
  logic               out_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               sat_q;

  logic [MAX_LEN-1:0] hist_next;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W:0]     fill_inc;   // one bit wider so fill+1 never wraps
  logic [LEN_W-1:0]   len_norm;
  logic               match;
  logic               count_up;
  logic [CNT_W-1:0]   cnt_plus;

  assign hist_next = {hist[MAX_LEN-2:0], bus.in};
  assign fill_inc  = {1'b0, fill} + (LEN_W+1)'(1);
  assign cnt_plus  = cnt_q + CNT_W'(1);

  // Only the low len bits of history and pattern take part in the compare.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len));
    end
  end

  // Out-of-range lengths are folded into 1..MAX_LEN at load time.
  always_comb begin
    len_norm = bus.cfg_len;
    if (bus.cfg_len == '0) begin
      len_norm = LEN_W'(1);
    end else if (bus.cfg_len > LEN_W'(MAX_LEN)) begin
      len_norm = LEN_W'(MAX_LEN);
    end
  end

  assign match = (fill_inc >= {1'b0, len}) &&
                 (((hist_next ^ pat) & len_mask) == '0);

  // A bit presented with cfg_we is discarded, so it can never count.
  assign count_up = bus.in_valid && !bus.cfg_we && match;

  always_ff @(posedge clk) begin
    if (!rst) begin
      hist  <= '0;
      fill  <= '0;
      pat   <= RST_PATTERN;
      len   <= LEN_W'(RST_LEN);
      ovl   <= RST_OVERLAP;
      out_q <= 1'b0;
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      if (bus.cfg_we) begin
        pat   <= bus.cfg_pattern;
        len   <= len_norm;
        ovl   <= bus.cfg_overlap;
        hist  <= '0;
        fill  <= '0;
        out_q <= 1'b0;
      end else if (bus.in_valid) begin
        hist  <= hist_next;
        out_q <= match;
        // Non-overlapping: history stays but must be refilled with len new bits.
        if (match && !ovl) begin
          fill <= '0;
        end else if (fill_inc > (LEN_W+1)'(MAX_LEN)) begin
          fill <= LEN_W'(MAX_LEN);
        end else begin
          fill <= fill_inc[LEN_W-1:0];
        end
      end else begin
        out_q <= 1'b0;
      end

      if (bus.cnt_clr) begin
        cnt_q <= '0;
        sat_q <= 1'b0;
      end else if (count_up && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_plus;
        sat_q <= (cnt_plus == CNT_MAX);
      end
    end
  end

  assign bus.out       = out_q;
  assign bus.match_cnt = cnt_q;
  assign bus.cnt_sat   = sat_q;
endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - directed self-checking bench for seq_detector_param
// Purpose: drives hand-written bit streams into two detector instances (8-bit
//   and 2-bit match counters) and compares out/match_cnt/cnt_sat with
//   hand-computed values one time unit after each rising edge.
module tb_seq_detector_param;
  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  seq_detector_param_if #(.MAX_LEN(8), .CNT_W(8)) a_if ();
  seq_detector_param_if #(.MAX_LEN(8), .CNT_W(2)) b_if ();

  seq_detector_param #(.MAX_LEN(8), .CNT_W(8)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  seq_detector_param #(.MAX_LEN(8), .CNT_W(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one valid bit to instance A for one edge.
  task automatic bit_a(input logic b);
    a_if.in_valid = 1'b1;
    a_if.in       = b;
    tick();
    a_if.in_valid = 1'b0;
  endtask

  task automatic bit_b(input logic b);
    b_if.in_valid = 1'b1;
    b_if.in       = b;
    tick();
    b_if.in_valid = 1'b0;
  endtask

  task automatic cfg_a(input logic [7:0] p, input logic [3:0] l, input logic o);
    a_if.cfg_we      = 1'b1;
    a_if.cfg_pattern = p;
    a_if.cfg_len     = l;
    a_if.cfg_overlap = o;
    tick();
    a_if.cfg_we      = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    total_cnt++;
    if (a_if.out !== 1'b0) $display("FAIL reset_out got %b want 0", a_if.out);
    else pass_cnt++;
    total_cnt++;
    if (a_if.match_cnt !== 8'd0) $display("FAIL reset_cnt got %0d want 0", a_if.match_cnt);
    else pass_cnt++;
    total_cnt++;
    if (a_if.cnt_sat !== 1'b0) $display("FAIL reset_sat got %b want 0", a_if.cnt_sat);
    else pass_cnt++;
  endtask

  task automatic test_overlap();
    logic [4:0] bits = 5'b10101;
    logic [4:0] exp  = 5'b00101;
    for (int i = 4; i >= 0; i--) begin
      bit_a(bits[i]);
      total_cnt++;
      if (a_if.out !== exp[i]) $display("FAIL overlap_out bit%0d got %b want %b", 4 - i, a_if.out, exp[i]);
      else pass_cnt++;
    end
    tick();
    total_cnt++;
    if (a_if.out !== 1'b0) $display("FAIL overlap_pulse_width got %b want 0", a_if.out);
    else pass_cnt++;
    total_cnt++;
    if (a_if.match_cnt !== 8'd2) $display("FAIL overlap_cnt got %0d want 2", a_if.match_cnt);
    else pass_cnt++;
    total_cnt++;
    if (a_if.cnt_sat !== 1'b0) $display("FAIL overlap_sat got %b want 0", a_if.cnt_sat);
    else pass_cnt++;
  endtask

  task automatic test_non_overlap();
    logic [6:0] bits = 7'b1010101;
    logic [6:0] exp  = 7'b0010001;
    a_if.cnt_clr = 1'b1;
    cfg_a(8'b0000_0101, 4'd3, 1'b0);
    a_if.cnt_clr = 1'b0;
    for (int i = 6; i >= 0; i--) begin
      bit_a(bits[i]);
      total_cnt++;
      if (a_if.out !== exp[i]) $display("FAIL nonovl_out bit%0d got %b want %b", 6 - i, a_if.out, exp[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (a_if.match_cnt !== 8'd2) $display("FAIL nonovl_cnt got %0d want 2", a_if.match_cnt);
    else pass_cnt++;
  endtask

  task automatic test_gapped();
    logic [2:0] bits = 3'b101;
    cfg_a(8'b0000_0101, 4'd3, 1'b1);
    for (int i = 2; i >= 0; i--) begin
      bit_a(bits[i]);
      total_cnt++;
      if (a_if.out !== (i == 0)) $display("FAIL gapped_out bit%0d got %b want %b", 2 - i, a_if.out, (i == 0));
      else pass_cnt++;
      if (i != 0) begin
        for (int g = 0; g < 2; g++) begin
          tick();
          total_cnt++;
          if (a_if.out !== 1'b0) $display("FAIL gapped_gap got %b want 0", a_if.out);
          else pass_cnt++;
        end
      end
    end
    tick();
    total_cnt++;
    if (a_if.out !== 1'b0) $display("FAIL gapped_after got %b want 0", a_if.out);
    else pass_cnt++;
  endtask

  task automatic test_long_pattern();
    logic [7:0] miss = 8'b1101_0010;
    logic [7:0] hit  = 8'b1101_0011;
    cfg_a(8'b1101_0011, 4'd8, 1'b1);
    for (int i = 7; i >= 0; i--) begin
      bit_a(miss[i]);
      total_cnt++;
      if (a_if.out !== 1'b0) $display("FAIL long_miss bit%0d got %b want 0", 7 - i, a_if.out);
      else pass_cnt++;
    end
    cfg_a(8'b1101_0011, 4'd8, 1'b1);
    for (int i = 7; i >= 0; i--) begin
      bit_a(hit[i]);
      total_cnt++;
      if (a_if.out !== (i == 0)) $display("FAIL long_hit bit%0d got %b want %b", 7 - i, a_if.out, (i == 0));
      else pass_cnt++;
    end
  endtask

  task automatic test_len_clamp();
    logic [7:0] hit  = 8'b1101_0011;
    logic [2:0] ones = 3'b101;
    // Length 15 folds to 8: only the full byte matches.
    cfg_a(8'b1101_0011, 4'd15, 1'b1);
    for (int i = 7; i >= 0; i--) begin
      bit_a(hit[i]);
      total_cnt++;
      if (a_if.out !== (i == 0)) $display("FAIL clamp_hi bit%0d got %b want %b", 7 - i, a_if.out, (i == 0));
      else pass_cnt++;
    end
    // Length 0 folds to 1 and upper pattern bits are ignored.
    cfg_a(8'b1111_1111, 4'd0, 1'b1);
    for (int i = 2; i >= 0; i--) begin
      bit_a(ones[i]);
      total_cnt++;
      if (a_if.out !== ones[i]) $display("FAIL clamp_zero bit%0d got %b want %b", 2 - i, a_if.out, ones[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_saturation();
    logic [8:0] bits = 9'b101010101;
    logic [8:0] exp  = 9'b001010101;
    logic [1:0] ecnt [9] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3};
    logic       esat [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 8; i >= 0; i--) begin
      bit_b(bits[i]);
      total_cnt++;
      if (b_if.out !== exp[i]) $display("FAIL sat_out bit%0d got %b want %b", 8 - i, b_if.out, exp[i]);
      else pass_cnt++;
      total_cnt++;
      if (b_if.match_cnt !== ecnt[8 - i]) $display("FAIL sat_cnt bit%0d got %0d want %0d", 8 - i, b_if.match_cnt, ecnt[8 - i]);
      else pass_cnt++;
      total_cnt++;
      if (b_if.cnt_sat !== esat[8 - i]) $display("FAIL sat_flag bit%0d got %b want %b", 8 - i, b_if.cnt_sat, esat[8 - i]);
      else pass_cnt++;
    end
    bit_b(1'b0);
    b_if.cnt_clr = 1'b1;
    bit_b(1'b1);
    b_if.cnt_clr = 1'b0;
    total_cnt++;
    if (b_if.out !== 1'b1) $display("FAIL clr_out got %b want 1", b_if.out);
    else pass_cnt++;
    total_cnt++;
    if (b_if.match_cnt !== 2'd0) $display("FAIL clr_cnt got %0d want 0", b_if.match_cnt);
    else pass_cnt++;
    total_cnt++;
    if (b_if.cnt_sat !== 1'b0) $display("FAIL clr_sat got %b want 0", b_if.cnt_sat);
    else pass_cnt++;
  endtask

  task automatic test_reset_reconfig();
    logic [4:0] bits = 5'b10101;
    logic [4:0] exp  = 5'b00101;
    // A mid-sequence reset drops the partial "10".
    bit_a(1'b1);
    bit_a(1'b0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    total_cnt++;
    if (a_if.match_cnt !== 8'd0) $display("FAIL rst_mid_cnt got %0d want 0", a_if.match_cnt);
    else pass_cnt++;
    bit_a(1'b1);
    total_cnt++;
    if (a_if.out !== 1'b0) $display("FAIL rst_mid_out got %b want 0", a_if.out);
    else pass_cnt++;
    // Reset restores 101 / len 3 / overlapping, replacing the byte pattern.
    cfg_a(8'b1101_0011, 4'd8, 1'b1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 4; i >= 0; i--) begin
      bit_a(bits[i]);
      total_cnt++;
      if (a_if.out !== exp[i]) $display("FAIL rst_cfg bit%0d got %b want %b", 4 - i, a_if.out, exp[i]);
      else pass_cnt++;
    end
    // Completing bit presented with cfg_we is dropped and history cleared.
    bit_a(1'b1);
    bit_a(1'b0);
    a_if.in_valid = 1'b1;
    a_if.in       = 1'b1;
    cfg_a(8'b0000_0101, 4'd3, 1'b1);
    total_cnt++;
    if (a_if.out !== 1'b0) $display("FAIL cfg_drop_out got %b want 0", a_if.out);
    else pass_cnt++;
    bit_a(1'b1);
    total_cnt++;
    if (a_if.out !== 1'b0) $display("FAIL cfg_hist_clr got %b want 0", a_if.out);
    else pass_cnt++;
    bit_a(1'b0);
    bit_a(1'b1);
    total_cnt++;
    if (a_if.out !== 1'b1) $display("FAIL cfg_after got %b want 1", a_if.out);
    else pass_cnt++;
    total_cnt++;
    if (a_if.match_cnt !== 8'd3) $display("FAIL cfg_after_cnt got %0d want 3", a_if.match_cnt);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt         = 0;
    total_cnt        = 0;
    rst              = 1'b0;
    a_if.in_valid    = 1'b0;
    a_if.in          = 1'b0;
    a_if.cfg_we      = 1'b0;
    a_if.cfg_pattern = '0;
    a_if.cfg_len     = '0;
    a_if.cfg_overlap = 1'b0;
    a_if.cnt_clr     = 1'b0;
    b_if.in_valid    = 1'b0;
    b_if.in          = 1'b0;
    b_if.cfg_we      = 1'b0;
    b_if.cfg_pattern = '0;
    b_if.cfg_len     = '0;
    b_if.cfg_overlap = 1'b0;
    b_if.cnt_clr     = 1'b0;

    test_reset();
    test_overlap();
    test_non_overlap();
    test_gapped();
    test_long_pattern();
    test_len_clamp();
    test_saturation();
    test_reset_reconfig();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised, runtime-programmable serial pattern detector. It is the successor to the fixed 3-bit "101" detector.
- Samples one serial bit per qualified clock and compares the last cfg_len bits against a programmable pattern.
- Raises a registered one-cycle match pulse and keeps a saturating match count.
- Supports overlapping and non-overlapping detection. Used wherever a serial stream needs framing/sync-word detection.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (2..16).
- RST_PATTERN, 8'b0000_0101, pattern loaded at reset (MAX_LEN bits, right-aligned).
- RST_LEN, 3, pattern length loaded at reset (1..MAX_LEN).
- RST_OVERLAP, 1, overlap mode loaded at reset (1 = overlapping, 0 = non-overlapping).
- CNT_W, 8, width of match counter.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-low reset.
- in_valid  input  1  qualifies in; the bit is consumed on the posedge where in_valid=1.
- in  input  1  serial data bit.
- cfg_we  input  1  load cfg_pattern/cfg_len/cfg_overlap this cycle.
- cfg_pattern  input  MAX_LEN  new pattern, right-aligned; bit [cfg_len-1] is expected first.
- cfg_len  input  $clog2(MAX_LEN+1)  new pattern length.
- cfg_overlap  input  1  new overlap mode.
- cnt_clr  input  1  clear match_cnt.
- out  output  1  registered match pulse.
- match_cnt  output  CNT_W  saturating count of matches.
- cnt_sat  output  1  high while match_cnt is all ones.

Behaviour:
- Reset (rst=0 at posedge):
  - Clears history, fill count, out, match_cnt and cnt_sat.
  - Loads pattern=RST_PATTERN, len=RST_LEN, overlap=RST_OVERLAP.
  - Reset overrides every other input and may occur mid-sequence; partial progress is discarded.
- State:
  - hist[MAX_LEN-1:0] shift register; fill counter saturating at MAX_LEN.
  - Active configuration registers: pat, len, ovl.
- Per posedge, with rst=1, priority order:
  - cfg_we=1: latch the new config, clear hist and fill, out<=0. A same-cycle in bit is discarded and cnt_clr still applies. The new config is effective from the next cycle.
  - Else if in_valid=1:
    - hist <= {hist[MAX_LEN-2:0], in}; fill <= min(fill+1, MAX_LEN).
    - match is true when (fill+1) >= len and the low len bits of the shifted hist equal pat[len-1:0].
    - out <= match.
  - Else: out <= 0; hist and fill hold.
- Latency: out is high for exactly the one cycle following the posedge that consumed the completing bit. Valid bits on consecutive cycles can produce back-to-back pulses.
- Overlap mode 1: history is kept after a match, so "101" on stream 10101 matches twice.
- Overlap mode 0: on a match, fill <= 0 and hist is kept. The next match needs len fresh bits after the match.
- Counter, on a match:
  - match_cnt <= match_cnt+1, saturating at 2^CNT_W-1.
  - cnt_sat is registered and asserts in the same cycle match_cnt reaches all ones.
- cnt_clr=1: match_cnt <= 0 and cnt_sat <= 0.
  - cnt_clr wins over a simultaneous increment; out still pulses for that match.
- cfg_len handling:
  - cfg_len=0 is treated as 1.
  - cfg_len>MAX_LEN is treated as MAX_LEN.
  - Pattern bits above len are ignored.
- Bit order: the first bit received aligns with pat[len-1]; the last bit received aligns with pat[0].

Test Plan:
1. Reset defaults, overlap; in_valid=1 every cycle, stream 1,0,1,0,1 -> out pulses the cycle after bits 3 and 5; match_cnt=2; cnt_sat=0.
2. cfg_we with pattern 3'b101, len=3, overlap=0; stream 1,0,1,0,1,0,1 -> pulses only after bits 3 and 7; match_cnt=2.
3. Gapped stream: bits 1,0,1 with in_valid low for 2 cycles between each bit -> single pulse one cycle after the third valid bit; out=0 during the gaps.
4. cfg len=8, pattern 8'b1101_0011; stream 1,1,0,1,0,0,1,0 (near miss) -> no pulse. Stream 1,1,0,1,0,0,1,1 -> one pulse; the 7-bit prefix alone gives no pulse.
5. CNT_W=2, overlap, stream 1,0,1,0,1,0,1,0,1 -> 4 matches, match_cnt=3 with cnt_sat=1 from the 3rd match. Then cnt_clr asserted on a matching cycle -> match_cnt=0, cnt_sat=0, out=1.
6. Reset and reconfiguration:
   - Stream 1,0, then rst=0 for 1 cycle, then 1 -> no pulse.
   - Config returns to 101/len 3/overlap 1 after reset.
   - cfg_we asserted together with a completing bit -> no pulse and history cleared.
